// File: rtl/fnd_scan_controller.sv
// ---------------------------------------------------------------------------
// fnd_scan_controller
//
// Captures a 14-bit binary value, converts it to four BCD digits with a
// sequential shift-add-3 (double-dabble) converter, and time-multiplexes the
// digits onto a shared segment path, one digit slot per SCAN_DIV clocks.
//
// Parameters:
//   SCAN_DIV       clocks per digit slot (>= 2)
//   BLANK_LEADING  1: leading zeros shown as blank code 4'hf
//
// Ports:
//   i_clk        in   system clock
//   i_reset_n    in   synchronous active-low reset
//   i_value      in   [13:0] unsigned value to display
//   i_load       in   single-cycle capture/convert request (IDLE only)
//   o_busy       out  conversion in progress
//   o_overflow   out  last accepted value exceeded 9999 (clamped)
//   o_bcd        out  [3:0] code for the selected digit (0-9 or 4'hf blank)
//   o_digit_sel  out  [3:0] active-low one-hot digit enable, bit 0 = ones
// ---------------------------------------------------------------------------
module fnd_scan_controller #(
  parameter int SCAN_DIV      = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [13:0] i_value,
  input  logic        i_load,
  output logic        o_busy,
  output logic        o_overflow,
  output logic [3:0]  o_bcd,
  output logic [3:0]  o_digit_sel
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2
  } state_t;

  state_t      state_reg;
  logic [15:0] acc_reg;       // BCD accumulator
  logic [13:0] shift_reg;     // binary bits still to be shifted in
  logic [3:0]  iter_reg;
  logic [15:0] disp_reg;      // {d3, d2, d1, d0}
  logic        busy_reg;
  logic        overflow_reg;

  logic [15:0] acc_adj;

  // Add-3 correction on every nibble >= 5 before each shift.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      assign acc_adj[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5) ?
                                  acc_reg[gi*4 +: 4] + 4'd3 :
                                  acc_reg[gi*4 +: 4];
    end
  endgenerate

  // Conversion FSM. The display registers only change in UPDATE so the
  // previous value keeps scanning while a conversion runs.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_reg    <= IDLE;
      acc_reg      <= '0;
      shift_reg    <= '0;
      iter_reg     <= '0;
      disp_reg     <= '0;
      busy_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_load) begin
            if (i_value > 14'd9999) begin
              shift_reg    <= 14'd9999;
              overflow_reg <= 1'b1;
            end else begin
              shift_reg    <= i_value;
              overflow_reg <= 1'b0;
            end
            acc_reg   <= '0;
            iter_reg  <= '0;
            busy_reg  <= 1'b1;
            state_reg <= CONVERT;
          end
        end
        CONVERT: begin
          acc_reg   <= {acc_adj[14:0], shift_reg[13]};
          shift_reg <= {shift_reg[12:0], 1'b0};
          iter_reg  <= iter_reg + 4'd1;
          if (iter_reg == 4'd13) begin
            state_reg <= UPDATE;
          end
        end
        UPDATE: begin
          disp_reg  <= acc_reg;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Digit k is a leading zero when d3..dk are all zero; d0 is always shown.
  logic [3:0] blank;
  assign blank[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_blank
      assign blank[gi] = (disp_reg[15:gi*4] == '0);
    end
  endgenerate

  logic [CNT_W-1:0] scan_reg;
  logic [1:0]       idx_reg;
  logic [3:0]       bcd_reg;
  logic [3:0]       sel_reg;
  logic [3:0]       code_next;

  always_comb begin
    code_next = disp_reg[{idx_reg, 2'b00} +: 4];
    if (BLANK_LEADING && blank[idx_reg]) begin
      code_next = 4'hf;
    end
  end

  // Scan timing. Code and select are registered from the same index so they
  // always switch together; a load never restarts the scan.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      scan_reg <= '0;
      idx_reg  <= 2'd0;
      bcd_reg  <= 4'h0;
      sel_reg  <= 4'b1110;
    end else begin
      if (scan_reg == CNT_LAST) begin
        scan_reg <= '0;
        idx_reg  <= idx_reg + 2'd1;
      end else begin
        scan_reg <= scan_reg + 1'b1;
      end
      bcd_reg <= code_next;
      sel_reg <= ~(4'b0001 << idx_reg);
    end
  end

  assign o_busy      = busy_reg;
  assign o_overflow  = overflow_reg;
  assign o_bcd       = bcd_reg;
  assign o_digit_sel = sel_reg;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Testbench for fnd_scan_controller with SCAN_DIV=4. Two instances share the
// inputs: one with leading-zero blanking, one without.
module tb_fnd_scan_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic [13:0] value = '0;
  logic        busy, ovf, busy_nb, ovf_nb;
  logic [3:0]  bcd, sel, bcd_nb, sel_nb;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fnd_scan_controller #(.SCAN_DIV(4), .BLANK_LEADING(1'b1)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_value(value), .i_load(load),
    .o_busy(busy), .o_overflow(ovf), .o_bcd(bcd), .o_digit_sel(sel)
  );

  fnd_scan_controller #(.SCAN_DIV(4), .BLANK_LEADING(1'b0)) dut_nb (
    .i_clk(clk), .i_reset_n(reset_n), .i_value(value), .i_load(load),
    .o_busy(busy_nb), .o_overflow(ovf_nb), .o_bcd(bcd_nb), .o_digit_sel(sel_nb)
  );

  task automatic do_load(input logic [13:0] v);
    @(negedge clk);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  // Counts negedges with busy high, starting at the current one.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  // Collects the code shown in each slot as {d3,d2,d1,d0}; a slot that
  // never appears reads back as x.
  task automatic read_digits(output logic [15:0] codes, output logic [15:0] codes_nb);
    logic [3:0] pat;
    int n;
    codes = 'x;
    codes_nb = 'x;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      pat = ~(4'b0001 << k);
      n = 0;
      while (sel !== pat && n < 40) begin
        n++;
        @(negedge clk);
      end
      if (n < 40) begin
        codes[k*4 +: 4]    = bcd;
        codes_nb[k*4 +: 4] = bcd_nb;
      end
    end
  endtask

  task automatic test_reset;
    logic [3:0] pat, code;
    int n, len;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    total++; if (bcd !== 4'h0) begin bad++; $display("FAIL reset_bcd got=%h exp=0", bcd); end
    total++; if (sel !== 4'b1110) begin bad++; $display("FAIL reset_sel got=%b exp=1110", sel); end
    reset_n = 1'b1;
    n = 0;
    while (sel === 4'b1110 && n < 20) begin n++; @(negedge clk); end
    for (int s = 1; s <= 4; s++) begin
      pat  = ~(4'b0001 << (s % 4));
      code = (s % 4 == 0) ? 4'h0 : 4'hf;
      total++; if (sel !== pat) begin bad++; $display("FAIL scan_sel slot=%0d got=%b exp=%b", s, sel, pat); end
      total++; if (bcd !== code) begin bad++; $display("FAIL scan_bcd slot=%0d got=%h exp=%h", s, bcd, code); end
      len = 0;
      while (sel === pat && len < 20) begin len++; @(negedge clk); end
      total++; if (len !== 4) begin bad++; $display("FAIL slot_len slot=%0d got=%0d exp=4", s, len); end
    end
  endtask

  task automatic test_load_1234;
    int c;
    logic [15:0] d, dn;
    do_load(14'd1234);
    wait_idle(c);
    total++; if (c !== 15) begin bad++; $display("FAIL busy_len_1234 got=%0d exp=15", c); end
    read_digits(d, dn);
    total++; if (d !== 16'h1234) begin bad++; $display("FAIL disp_1234 got=%h exp=1234", d); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_1234 got=%b exp=0", ovf); end
  endtask

  task automatic test_blanking;
    int c;
    logic [15:0] d, dn;
    do_load(14'd7);
    wait_idle(c);
    read_digits(d, dn);
    total++; if (d !== 16'hfff7) begin bad++; $display("FAIL disp_7 got=%h exp=fff7", d); end
    total++; if (dn !== 16'h0007) begin bad++; $display("FAIL disp_7_noblank got=%h exp=0007", dn); end
    do_load(14'd0);
    wait_idle(c);
    read_digits(d, dn);
    total++; if (d !== 16'hfff0) begin bad++; $display("FAIL disp_0 got=%h exp=fff0", d); end
    total++; if (dn !== 16'h0000) begin bad++; $display("FAIL disp_0_noblank got=%h exp=0000", dn); end
  endtask

  task automatic test_overflow;
    int c;
    logic [15:0] d, dn;
    do_load(14'd12000);
    wait_idle(c);
    read_digits(d, dn);
    total++; if (d !== 16'h9999) begin bad++; $display("FAIL disp_12000 got=%h exp=9999", d); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_12000 got=%b exp=1", ovf); end
    do_load(14'd5);
    wait_idle(c);
    read_digits(d, dn);
    total++; if (d !== 16'hfff5) begin bad++; $display("FAIL disp_5 got=%h exp=fff5", d); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_5 got=%b exp=0", ovf); end
  endtask

  task automatic test_ignored_load;
    int c;
    logic [15:0] d, dn;
    do_load(14'd42);
    repeat (4) @(negedge clk);
    value = 14'd9999;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    wait_idle(c);
    total++; if (c !== 10) begin bad++; $display("FAIL busy_rest_42 got=%0d exp=10", c); end
    read_digits(d, dn);
    total++; if (d !== 16'hff42) begin bad++; $display("FAIL disp_42 got=%h exp=ff42", d); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_42 got=%b exp=0", ovf); end
  endtask

  task automatic test_reset_mid;
    int c;
    logic [15:0] d, dn;
    do_load(14'd8888);
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    read_digits(d, dn);
    total++; if (d !== 16'hfff0) begin bad++; $display("FAIL midreset_disp got=%h exp=fff0", d); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy_late got=%b exp=0", busy); end
    do_load(14'd8888);
    wait_idle(c);
    total++; if (c !== 15) begin bad++; $display("FAIL busy_len_8888 got=%0d exp=15", c); end
    read_digits(d, dn);
    total++; if (d !== 16'h8888) begin bad++; $display("FAIL disp_8888 got=%h exp=8888", d); end
  endtask

  initial begin
    test_reset;
    test_load_1234;
    test_blanking;
    test_overflow;
    test_ignored_load;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fnd_scan_controller.md
# fnd_scan_controller

Upstream stage of the 4-digit FND display path. It captures a binary value, converts it to four BCD digits with a sequential shift-add-3 converter, and time-multiplexes the digits onto the shared segment bus. Each cycle it presents one 4-bit code (`o_bcd`) to the BCD-to-FND decoder and drives the matching active-low digit-select line. Codes 0-9 are digits; code 4'hf is a blank digit, which the decoder renders as all segments off (8'hff).

## Interface
Parameters:
- `SCAN_DIV`, default 100000: clocks per digit slot (1 kHz digit rate at 100 MHz); legal values are ≥ 2.
- `BLANK_LEADING`, default 1: when 1, leading zeros are blanked; when 0, all four digits are always shown.

Ports:
- `i_clk`  in  1  system clock. One clock domain; reset is synchronous and active-low.
- `i_reset_n`  in  1  synchronous active-low reset.
- `i_value`  in  14  unsigned binary value to display.
- `i_load`  in  1  single-cycle request to capture `i_value` and start a conversion.
- `o_busy`  out  1  high while a conversion is in progress; loads are ignored while high.
- `o_overflow`  out  1  high if the last accepted value exceeded 9999.
- `o_bcd`  out  4  code for the currently selected digit; feeds the decoder's `i_value`.
- `o_digit_sel`  out  4  active-low one-hot digit enable; bit 0 is the ones digit.

## Operation
- **FSM states:**
  - IDLE: on `i_load=1`, capture the clamped value, set the overflow flag and go to CONVERT.
  - CONVERT: runs exactly 14 iterations, then goes to UPDATE.
  - UPDATE: copies the result to the display registers, then returns to IDLE.
- **Clamp:**
  - If `i_value > 9999`, the value converted is 9999 and `o_overflow` becomes 1.
  - Otherwise `o_overflow` becomes 0.
  - `o_overflow` holds its value until the next accepted load.
- **Conversion (double-dabble):**
  - Uses a 16-bit BCD accumulator plus a 14-bit shift register.
  - Each iteration first adds 3 to every BCD nibble that is ≥ 5, then shifts the combined register left by 1 with the binary MSB entering the accumulator LSB.
  - No nibble exceeds 9 after the final iteration.
- **Display registers:**
  - Four nibbles d3..d0 (d0 = ones).
  - Written only in UPDATE, so the previous value keeps scanning undisturbed during conversion.
- **Scan counter:**
  - Counts 0..`SCAN_DIV`-1 and wraps.
  - At terminal count, the 2-bit digit index advances 0→1→2→3→0.
- **Digit select:** `o_digit_sel = ~(4'b0001 << index)`.
- **Blanking (`BLANK_LEADING=1`):**
  - Digit k is driven as 4'hf when k > 0 and d3..dk are all zero.
  - d0 is never blanked.
- **Ignored loads:** `i_load` while not in IDLE is dropped, with no queuing and no side effects.
- **Codes not driven:** 4'ha (dot) is never generated by this block.

## Timing
- **Reset values:**
  - Outputs: `o_busy=0`, `o_overflow=0`, `o_bcd=4'h0`, `o_digit_sel=4'b1110`.
  - Internal: state IDLE, scan counter 0, digit index 0, display registers 0.
- **Load accepted at edge T:**
  - `o_busy` is 1 from after edge T.
  - Iterations occur at edges T+1..T+14.
  - UPDATE occurs at edge T+15: display registers are written and `o_busy` returns to 0.
  - `o_busy` is high for exactly 15 cycles.
  - The earliest next accepted load is at edge T+16.
- **New digits on `o_bcd`:** visible from the edge after T+15, and only on the then-selected digit slot. The scan is never restarted by a load.
- **Registered outputs:** `o_bcd` and `o_digit_sel` change on the same edge, so there is no cycle where the select and the code mismatch.
- **Slot length:** every select pattern persists for exactly `SCAN_DIV` cycles.
- **Reset mid-conversion:**
  - Aborts to IDLE and clears the display to 0.
  - Clears `o_busy` and `o_overflow` on that edge; the partial result is discarded.
- **Load and terminal count in the same cycle:** both take effect independently.

## Test plan
All scenarios use `SCAN_DIV=4` unless stated otherwise.
- **Reset:** assert reset 3 cycles → outputs are 0/0/4'h0/4'b1110. After release, with no load, the slots show 0,f,f,f with select 1110,1101,1011,0111 rotating every 4 cycles.
- **Load 1234:**
  - `o_busy` is high for exactly 15 cycles.
  - Afterwards, select 1110/1101/1011/0111 pairs with `o_bcd` 4/3/2/1.
  - `o_overflow=0`.
- **Load 7, load 0 and `BLANK_LEADING=0`:**
  - Load 7 → 7,f,f,f.
  - Load 0 → 0,f,f,f.
  - Rerun with `BLANK_LEADING=0` and load 7 → 7,0,0,0.
- **Load 12000** → display 9,9,9,9 and `o_overflow=1`. A following load of 5 → 5,f,f,f and `o_overflow=0`.
- **Load 42**, then pulse `i_load` with 9999 at busy cycle 5 → the second load is ignored and the display shows 2,4,f,f.
- **Reset during conversion:**
  - Load 8888, then assert reset at busy cycle 8 → after reset, the display is 0,f,f,f and `o_busy=0`.
  - A fresh load of 8888 completes → 8,8,8,8.
